pending_encoder16to4: RTL and testbench

//  Sequential 16-to-4 encoder: accepts a 16-bit request vector, drains it one set bit per

---
 rtl/pending_encoder16to4.sv | 121 ++++++++++++
 tb/tb_pending_encoder16to4.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pending_encoder16to4.sv
// ============================================================================
// Module   : pending_encoder16to4
// Brief    : Drains a multi-hot request vector one set bit per beat, emitting
//            each bit index on a valid/ready stream. Optional empty beat for
//            zero vectors is enabled by defining ENC_EMPTY_BEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pending_encoder16to4 #(
    parameter int N       = 16,
    parameter int IDX_W   = 4,
    parameter int DESCEND = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_empty,
    output logic             busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
`ifdef ENC_EMPTY_BEAT_EN
    localparam logic [1:0] c_EMPTY = 2'd2;
`endif

    logic [1:0]       r_state;
    logic [N-1:0]     r_pending;
    logic [1:0]       w_state_nxt;
    logic [N-1:0]     w_pending_nxt;
    logic [IDX_W-1:0] w_sel_idx;
    logic [N-1:0]     w_sel_mask;
    logic             w_one_hot;

    // Priority pick from the pending register only; the last match in loop order wins.
    always_comb begin
        w_sel_idx = '0;
        if (DESCEND != 0) begin
            for (int i = 0; i < N; i++) begin
                if (r_pending[i]) w_sel_idx = IDX_W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r_pending[i]) w_sel_idx = IDX_W'(i);
            end
        end
    end

    assign w_sel_mask = {{(N-1){1'b0}}, 1'b1} << w_sel_idx;
    assign w_one_hot  = (r_pending != '0) && ((r_pending & (r_pending - N'(1))) == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    if (in_vec != '0) begin
                        w_pending_nxt = in_vec;
                        w_state_nxt   = c_DRAIN;
                    end
`ifdef ENC_EMPTY_BEAT_EN
                    else begin
                        w_state_nxt = c_EMPTY;
                    end
`endif
                end
            end
            c_DRAIN: begin
                if (out_ready) begin
                    w_pending_nxt = r_pending & ~w_sel_mask;
                    if (w_one_hot) w_state_nxt = c_IDLE;
                end
            end
`ifdef ENC_EMPTY_BEAT_EN
            c_EMPTY: begin
                if (out_ready) w_state_nxt = c_IDLE;
            end
`endif
            default: begin
                w_state_nxt   = c_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    // All stream outputs are functions of registered state, never of inputs.
    assign in_ready = (r_state == c_IDLE);
    assign busy     = (r_state != c_IDLE);

`ifdef ENC_EMPTY_BEAT_EN
    assign out_valid = (r_state == c_DRAIN) || (r_state == c_EMPTY);
    assign out_empty = (r_state == c_EMPTY);
    assign out_last  = ((r_state == c_DRAIN) && w_one_hot) || (r_state == c_EMPTY);
`else
    assign out_valid = (r_state == c_DRAIN);
    assign out_empty = 1'b0;
    assign out_last  = (r_state == c_DRAIN) && w_one_hot;
`endif
    assign out_idx = (r_state == c_DRAIN) ? w_sel_idx : '0;

endmodule

`default_nettype wire

// File: tb/tb_pending_encoder16to4.sv
// ============================================================================
// Module   : tb_pending_encoder16to4
// Brief    : Scoreboard bench driving an ascending and a descending encoder
//            with identical stimulus; ENC_EMPTY_BEAT_EN selects expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pending_encoder16to4;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic       empty;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_vec;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_last0, out_empty0, busy0;
    logic [3:0]  out_idx0;
    logic        in_ready1, out_valid1, out_last1, out_empty1, busy1;
    logic [3:0]  out_idx1;

    beat_t q0[$];
    beat_t q1[$];
    beat_t e0, e1;
    int    checks   = 0;
    int    failures = 0;

    pending_encoder16to4 #(.N(16), .IDX_W(4), .DESCEND(0)) u_asc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_vec(in_vec), .out_valid(out_valid0), .out_ready(out_ready),
        .out_idx(out_idx0), .out_last(out_last0), .out_empty(out_empty0), .busy(busy0)
    );

    pending_encoder16to4 #(.N(16), .IDX_W(4), .DESCEND(1)) u_desc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_vec(in_vec), .out_valid(out_valid1), .out_ready(out_ready),
        .out_idx(out_idx1), .out_last(out_last1), .out_empty(out_empty1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: walk the vector in each priority order and queue beats.
    function automatic void push_vec(input logic [15:0] v);
        int    cnt = 0;
        int    n;
        beat_t b;
        for (int i = 0; i < 16; i++) if (v[i]) cnt++;
        if (cnt == 0) begin
`ifdef ENC_EMPTY_BEAT_EN
            b.idx = 4'd0; b.last = 1'b1; b.empty = 1'b1;
            q0.push_back(b);
            q1.push_back(b);
`endif
            return;
        end
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                n++;
                b.idx = 4'(i); b.last = (n == cnt); b.empty = 1'b0;
                q0.push_back(b);
            end
        end
        n = 0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                n++;
                b.idx = 4'(i); b.last = (n == cnt); b.empty = 1'b0;
                q1.push_back(b);
            end
        end
    endfunction

    // Handshakes are judged half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_ready === 1'b1) begin
            if (out_valid0 === 1'b1) begin
                if (q0.size() == 0) check("unexpected_beat_asc", {28'd0, out_idx0}, 32'hFFFF_FFFF);
                else begin
                    e0 = q0.pop_front();
                    check("beat_asc", {26'd0, out_idx0, out_last0, out_empty0}, {26'd0, e0});
                end
            end
            if (out_valid1 === 1'b1) begin
                if (q1.size() == 0) check("unexpected_beat_desc", {28'd0, out_idx1}, 32'hFFFF_FFFF);
                else begin
                    e1 = q1.pop_front();
                    check("beat_desc", {26'd0, out_idx1, out_last1, out_empty1}, {26'd0, e1});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        int n = 0;
        while (in_ready0 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", {31'd0, in_ready0}, 32'd1);
        in_valid = 1'b1;
        in_vec   = v;
        push_vec(v);
        tick();
        in_valid = 1'b0;
        in_vec   = 16'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && in_ready0 === 1'b1 && in_ready1 === 1'b1)
               && n < 60) begin
            tick();
            n++;
        end
        check(tag, {31'd0, (n < 60)}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 16'h0000;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_out_last", {31'd0, out_last0}, 32'd0);
        check("rst_out_empty", {31'd0, out_empty0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Four beats back to back, then one idle bubble.
        send(16'h8421);
        check("t1_valid_k1", {31'd0, out_valid0}, 32'd1);
        check("t1_ready_k1", {31'd0, in_ready0}, 32'd0);
        tick(); tick(); tick();
        check("t1_idx_last", {28'd0, out_idx0}, 32'd15);
        check("t1_last_flag", {31'd0, out_last0}, 32'd1);
        tick();
        check("t1_ready_after", {31'd0, in_ready0}, 32'd1);
        check("t1_valid_after", {31'd0, out_valid0}, 32'd0);
        check("t1_drained", q0.size(), 32'd0);

        // Back-pressure holds the beat stable.
        out_ready = 1'b0;
        send(16'h0003);
        for (int c = 0; c < 3; c++) begin
            check("t2_hold_valid", {31'd0, out_valid0}, 32'd1);
            check("t2_hold_idx", {28'd0, out_idx0}, 32'd0);
            check("t2_hold_last", {31'd0, out_last0}, 32'd0);
            check("t2_hold_idx_desc", {28'd0, out_idx1}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_idle("t2_done");

        // Full vector; input changes mid-drain must be ignored.
        send(16'hFFFF);
        for (int c = 0; c < 15; c++) begin
            check("t3_in_ready", {31'd0, in_ready0}, 32'd0);
            check("t3_busy", {31'd0, busy0}, 32'd1);
            if (c == 2) begin in_valid = 1'b1; in_vec = 16'h1234; end
            if (c == 6) in_valid = 1'b0;
            tick();
        end
        wait_idle("t3_done");

        // Descending order on the second instance.
        send(16'h8421);
        check("t4_first_desc", {28'd0, out_idx1}, 32'd15);
        wait_idle("t4_done");

        // Reset mid-drain discards remaining bits.
        send(16'hFFFF);
        tick();
        tick();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        tick();
        rst_n = 1'b1;
        check("t5_valid", {31'd0, out_valid0}, 32'd0);
        check("t5_busy", {31'd0, busy0}, 32'd0);
        check("t5_ready", {31'd0, in_ready0}, 32'd1);
        send(16'h0010);
        check("t5_single_idx", {28'd0, out_idx0}, 32'd4);
        check("t5_single_last", {31'd0, out_last0}, 32'd1);
        wait_idle("t5_done");

        // Zero vector.
        send(16'h0000);
`ifdef ENC_EMPTY_BEAT_EN
        check("t6_empty_valid", {31'd0, out_valid0}, 32'd1);
        check("t6_empty_flag", {31'd0, out_empty0}, 32'd1);
`else
        check("t6_no_beat", {31'd0, out_valid0}, 32'd0);
        check("t6_ready", {31'd0, in_ready0}, 32'd1);
`endif
        wait_idle("t6_done");

        // Boundary single bits and random vectors under random back-pressure.
        send(16'h0001);
        wait_idle("b_bit0");
        send(16'h8000);
        wait_idle("b_bit15");
        for (int r = 0; r < 6; r++) begin
            send(16'($urandom));
            for (int c = 0; c < 60 && (q0.size() != 0 || in_ready0 !== 1'b1); c++) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            out_ready = 1'b1;
            wait_idle("rand_done");
        end

        check("final_q_asc", q0.size(), 32'd0);
        check("final_q_desc", q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
